// File: rtl/ysyx_22040931_mem_arbiter.sv
// ysyx_22040931_mem_arbiter
//   Shares the single memory port between instruction fetch (IF, read-only)
//   and load/store (MEM). One transaction is outstanding at a time. The block
//   builds the byte write mask and lane-aligned store data, and routes each
//   response back to the requester that issued it.
//
// Ports
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   if_req_*  / if_rsp_* : IF fetch request (valid/ready/addr) and response pulse
//   mem_req_* / mem_rsp_*: MEM load/store request and response pulse
//   bus_req_* / bus_*    : memory port request (8-byte aligned addr, mask, data)
//   bus_rsp_*            : memory port response
//   arb_err              : sticky watchdog error (0 unless the watchdog is built)
//
// Build option
//   YSYX_22040931_ARB_TIMEOUT_EN : enables the TIMEOUT_CYC watchdog on
//   outstanding transactions. When undefined the FSM waits indefinitely.
module ysyx_22040931_mem_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_wr,
  input  logic [1:0]        mem_req_size,
  input  logic [63:0]       mem_req_wdata,
  output logic              mem_rsp_valid,
  output logic [63:0]       mem_rsp_rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_rsp_valid,
  input  logic [63:0]       bus_rsp_rdata,
  output logic              arb_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE_IF  = 3'd1;
  localparam logic [2:0] S_ISSUE_MEM = 3'd2;
  localparam logic [2:0] S_WAIT_IF   = 3'd3;
  localparam logic [2:0] S_WAIT_MEM  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                bus_req_valid_q, bus_req_valid_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                bus_wr_q, bus_wr_d;
  logic [63:0]         bus_wdata_q, bus_wdata_d;
  logic [7:0]          bus_wmask_q, bus_wmask_d;
  logic                addr2_q, addr2_d;
  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]         if_rsp_data_q, if_rsp_data_d;
  logic                mem_rsp_valid_q, mem_rsp_valid_d;
  logic [63:0]         mem_rsp_rdata_q, mem_rsp_rdata_d;

  logic                idle_c, starved_c, grant_if_c, grant_mem_c;
  logic [2:0]          mem_lane_c;
  logic [7:0]          mem_mask_c;
  logic [63:0]         mem_wdata_c;

`ifdef YSYX_22040931_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            arb_err_q, arb_err_d;
  logic            unused_c;
  assign unused_c = ^if_req_addr[1:0];
`else
  logic            unused_c;
  assign unused_c = ^{if_req_addr[1:0], 32'(TIMEOUT_CYC)};
`endif

  // Arbitration: MEM has priority unless IF has been passed over STARVE_LIMIT times.
  assign idle_c      = (state_q == S_IDLE) && !reset;
  assign starved_c   = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign grant_if_c  = idle_c && if_req_valid && (!mem_req_valid || starved_c);
  assign grant_mem_c = idle_c && mem_req_valid && !grant_if_c;

  assign if_req_ready  = grant_if_c;
  assign mem_req_ready = grant_mem_c;

  // Byte-lane mask and store data aligned to the 8-byte bus word.
  always_comb begin
    mem_lane_c = mem_req_addr[2:0];
    mem_mask_c = 8'h00;
    if (mem_req_wr) begin
      case (mem_req_size)
        2'd0:    mem_mask_c = 8'h01 << mem_lane_c;
        2'd1:    mem_mask_c = 8'h03 << {mem_lane_c[2:1], 1'b0};
        2'd2:    mem_mask_c = mem_lane_c[2] ? 8'hF0 : 8'h0F;
        default: mem_mask_c = 8'hFF;
      endcase
    end
    mem_wdata_c = mem_req_wr ? (mem_req_wdata << {mem_lane_c, 3'b000}) : 64'h0;
  end

  // Next-state and output logic.
  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_addr_d      = bus_addr_q;
    bus_wr_d        = bus_wr_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wmask_d     = bus_wmask_q;
    addr2_d         = addr2_q;
    if_rsp_valid_d  = 1'b0;
    if_rsp_data_d   = 32'h0;
    mem_rsp_valid_d = 1'b0;
    mem_rsp_rdata_d = 64'h0;

    case (state_q)
      S_IDLE: begin
        if (grant_if_c) begin
          state_d         = S_ISSUE_IF;
          starve_d        = '0;
          bus_req_valid_d = 1'b1;
          bus_addr_d      = {if_req_addr[ADDR_W-1:3], 3'b000};
          bus_wr_d        = 1'b0;
          bus_wdata_d     = 64'h0;
          bus_wmask_d     = 8'h00;
          addr2_d         = if_req_addr[2];
        end else if (grant_mem_c) begin
          state_d         = S_ISSUE_MEM;
          if (if_req_valid && !starved_c) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          bus_req_valid_d = 1'b1;
          bus_addr_d      = {mem_req_addr[ADDR_W-1:3], 3'b000};
          bus_wr_d        = mem_req_wr;
          bus_wdata_d     = mem_wdata_c;
          bus_wmask_d     = mem_mask_c;
          addr2_d         = mem_req_addr[2];
        end
      end
      S_ISSUE_IF, S_ISSUE_MEM: begin
        // Responses during issue are stray and dropped.
        if (bus_req_ready) begin
          bus_req_valid_d = 1'b0;
          state_d         = (state_q == S_ISSUE_IF) ? S_WAIT_IF : S_WAIT_MEM;
        end
      end
      S_WAIT_IF: begin
        if (bus_rsp_valid) begin
          state_d        = S_IDLE;
          if_rsp_valid_d = 1'b1;
          if_rsp_data_d  = addr2_q ? bus_rsp_rdata[63:32] : bus_rsp_rdata[31:0];
        end
      end
      S_WAIT_MEM: begin
        if (bus_rsp_valid) begin
          state_d         = S_IDLE;
          mem_rsp_valid_d = 1'b1;
          mem_rsp_rdata_d = bus_rsp_rdata;
        end
      end
      default: begin
        state_d         = S_IDLE;
        bus_req_valid_d = 1'b0;
      end
    endcase

`ifdef YSYX_22040931_ARB_TIMEOUT_EN
    // Watchdog: abort the outstanding transaction and answer the owner with 0.
    arb_err_d = arb_err_q;
    to_cnt_d  = '0;
    if (state_q != S_IDLE) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        state_d         = S_IDLE;
        bus_req_valid_d = 1'b0;
        arb_err_d       = 1'b1;
        if_rsp_data_d   = 32'h0;
        mem_rsp_rdata_d = 64'h0;
        if_rsp_valid_d  = (state_q == S_ISSUE_IF)  || (state_q == S_WAIT_IF);
        mem_rsp_valid_d = (state_q == S_ISSUE_MEM) || (state_q == S_WAIT_MEM);
      end else if (state_d != S_IDLE) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      starve_q        <= '0;
      bus_req_valid_q <= 1'b0;
      bus_addr_q      <= '0;
      bus_wr_q        <= 1'b0;
      bus_wdata_q     <= 64'h0;
      bus_wmask_q     <= 8'h00;
      addr2_q         <= 1'b0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= 32'h0;
      mem_rsp_valid_q <= 1'b0;
      mem_rsp_rdata_q <= 64'h0;
    end else begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_addr_q      <= bus_addr_d;
      bus_wr_q        <= bus_wr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wmask_q     <= bus_wmask_d;
      addr2_q         <= addr2_d;
      if_rsp_valid_q  <= if_rsp_valid_d;
      if_rsp_data_q   <= if_rsp_data_d;
      mem_rsp_valid_q <= mem_rsp_valid_d;
      mem_rsp_rdata_q <= mem_rsp_rdata_d;
    end
  end

`ifdef YSYX_22040931_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end
  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

  assign bus_req_valid = bus_req_valid_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wr        = bus_wr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wmask     = bus_wmask_q;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign mem_rsp_valid = mem_rsp_valid_q;
  assign mem_rsp_rdata = mem_rsp_rdata_q;

endmodule

// File: tb/tb_ysyx_22040931_mem_arbiter.sv
// Directed bench for ysyx_22040931_mem_arbiter (default build, watchdog off).
module tb_ysyx_22040931_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wr;
  logic [1:0]  mem_req_size;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_wr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_rdata;
  logic        arb_err;

  int tests_run;
  int tests_failed;

  ysyx_22040931_mem_arbiter #(
    .ADDR_W(64), .STARVE_LIMIT(4), .TIMEOUT_CYC(8)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wr(mem_req_wr), .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .arb_err(arb_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called just after a grant edge: accept at once, respond the next cycle.
  task automatic bus_serve(input logic [63:0] rdata);
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = rdata;
    step();
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 64'h0;
  endtask

  // Waits (bounded) for a grant and steps past the handshake edge.
  task automatic wait_grant(output logic g_if, output logic g_mem);
    g_if  = 1'b0;
    g_mem = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (if_req_ready || mem_req_ready) begin
        g_if  = if_req_ready;
        g_mem = mem_req_ready;
        step();
        return;
      end
      step();
    end
    chk("grant_wait", 64'(if_req_ready | mem_req_ready), 64'h1);
  endtask

  // Store/load vectors: addr, size, wr, wdata -> mask, aligned data.
  localparam int NV = 6;
  logic [63:0] v_addr  [NV] = '{64'h8000_0106, 64'h8000_0003, 64'h8000_0004,
                                64'h8000_0010, 64'h8000_000D, 64'h8000_0008};
  logic [1:0]  v_size  [NV] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2};
  logic        v_wr    [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [63:0] v_wdata [NV] = '{64'h1234, 64'hFFFF_FFFF_FFFF_FFAB, 64'h1122_3344,
                                64'h0123_4567_89AB_CDEF, 64'hBEEF, 64'h9999};
  logic [7:0]  v_mask  [NV] = '{8'hC0, 8'h08, 8'hF0, 8'hFF, 8'h30, 8'h00};
  logic [63:0] v_bdata [NV] = '{64'h1234_0000_0000_0000, 64'hFFFF_FFFF_AB00_0000,
                                64'h1122_3344_0000_0000, 64'h0123_4567_89AB_CDEF,
                                64'h00BE_EF00_0000_0000, 64'h0};

  logic exp_if_grant [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    logic g_if, g_mem;
    logic [63:0] rd;
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    if_req_valid  = 1'b0;
    if_req_addr   = 64'h0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 64'h0;
    mem_req_wr    = 1'b0;
    mem_req_size  = 2'd0;
    mem_req_wdata = 64'h0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 64'h0;

    // Reset: outputs idle, no ready even with a request pending.
    repeat (3) step();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0004;
    #1;
    chk("rst_if_ready", 64'(if_req_ready), 64'h0);
    chk("rst_bus_valid", 64'(bus_req_valid), 64'h0);
    chk("rst_bus_addr", bus_addr, 64'h0);
    chk("rst_if_rsp", 64'(if_rsp_valid), 64'h0);
    chk("rst_mem_rsp", 64'(mem_rsp_valid), 64'h0);
    chk("rst_arb_err", 64'(arb_err), 64'h0);
    reset = 1'b0;
    #1;

    // IF fetch of the upper word.
    chk("if_ready", 64'(if_req_ready), 64'h1);
    chk("if_mem_ready", 64'(mem_req_ready), 64'h0);
    step();
    if_req_valid = 1'b0;
    chk("if_bus_valid", 64'(bus_req_valid), 64'h1);
    chk("if_bus_addr", bus_addr, 64'h8000_0000);
    chk("if_bus_wmask", 64'(bus_wmask), 64'h0);
    chk("if_bus_wr", 64'(bus_wr), 64'h0);
    chk("if_rsp_early", 64'(if_rsp_valid), 64'h0);
    bus_serve(64'hDEAD_BEEF_0000_0013);
    chk("if_rsp_valid", 64'(if_rsp_valid), 64'h1);
    chk("if_rsp_data", 64'(if_rsp_data), 64'hDEAD_BEEF);
    chk("if_rsp_mem_quiet", 64'(mem_rsp_valid), 64'h0);
    step();
    chk("if_rsp_pulse_end", 64'(if_rsp_valid), 64'h0);
    chk("if_rsp_data_zero", 64'(if_rsp_data), 64'h0);

    // MEM store/load vectors.
    for (int i = 0; i < NV; i++) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = v_addr[i];
      mem_req_size  = v_size[i];
      mem_req_wr    = v_wr[i];
      mem_req_wdata = v_wdata[i];
      #1;
      chk($sformatf("v%0d_mem_ready", i), 64'(mem_req_ready), 64'h1);
      step();
      mem_req_valid = 1'b0;
      chk($sformatf("v%0d_bus_addr", i), bus_addr, v_addr[i] & ~64'h7);
      chk($sformatf("v%0d_bus_wr", i), 64'(bus_wr), 64'(v_wr[i]));
      chk($sformatf("v%0d_bus_wmask", i), 64'(bus_wmask), 64'(v_mask[i]));
      if (v_wr[i]) chk($sformatf("v%0d_bus_wdata", i), bus_wdata, v_bdata[i]);
      rd = 64'hA5A5_0000_0000_0000 | 64'(i);
      bus_serve(rd);
      chk($sformatf("v%0d_mem_rsp", i), 64'(mem_rsp_valid), 64'h1);
      chk($sformatf("v%0d_mem_rdata", i), mem_rsp_rdata, rd);
      chk($sformatf("v%0d_if_quiet", i), 64'(if_rsp_valid), 64'h0);
      step();
      chk($sformatf("v%0d_mem_rsp_end", i), 64'(mem_rsp_valid), 64'h0);
    end

    // Both requesters valid continuously: MEM x4, then IF, then MEM.
    if_req_valid  = 1'b1;
    if_req_addr   = 64'h8000_0200;
    mem_req_valid = 1'b1;
    mem_req_addr  = 64'h8000_0300;
    mem_req_wr    = 1'b0;
    mem_req_size  = 2'd3;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g_if, g_mem);
      chk($sformatf("starve_g%0d_if", k), 64'(g_if), 64'(exp_if_grant[k]));
      chk($sformatf("starve_g%0d_mem", k), 64'(g_mem), 64'(!exp_if_grant[k]));
      bus_serve(64'h5555_6666_7777_8888);
      chk($sformatf("starve_r%0d_if", k), 64'(if_rsp_valid), 64'(exp_if_grant[k]));
      chk($sformatf("starve_r%0d_mem", k), 64'(mem_rsp_valid), 64'(!exp_if_grant[k]));
    end
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    step();

    // Bus stalls 5 cycles in ISSUE_MEM with IF waiting and stray responses.
    mem_req_valid = 1'b1;
    mem_req_addr  = 64'h8000_0021;
    mem_req_wr    = 1'b1;
    mem_req_size  = 2'd0;
    mem_req_wdata = 64'h5A;
    if_req_valid  = 1'b1;
    if_req_addr   = 64'h8000_0080;
    #1;
    chk("stall_mem_ready", 64'(mem_req_ready), 64'h1);
    chk("stall_if_ready0", 64'(if_req_ready), 64'h0);
    step();
    mem_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 64'hBAD;
      #1;
      chk($sformatf("stall%0d_valid", c), 64'(bus_req_valid), 64'h1);
      chk($sformatf("stall%0d_addr", c), bus_addr, 64'h8000_0020);
      chk($sformatf("stall%0d_wdata", c), bus_wdata, 64'h5A00);
      chk($sformatf("stall%0d_wmask", c), 64'(bus_wmask), 64'h02);
      chk($sformatf("stall%0d_if_ready", c), 64'(if_req_ready), 64'h0);
      chk($sformatf("stall%0d_mem_rsp", c), 64'(mem_rsp_valid), 64'h0);
      step();
    end
    if_req_valid  = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 64'h0;
    bus_serve(64'h77);
    chk("stall_mem_rsp", 64'(mem_rsp_valid), 64'h1);
    chk("stall_mem_rdata", mem_rsp_rdata, 64'h77);
    chk("stall_if_quiet", 64'(if_rsp_valid), 64'h0);
    step();

    // Reset while waiting for an IF response; the late response is dropped.
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0040;
    #1;
    chk("rw_if_ready", 64'(if_req_ready), 64'h1);
    step();
    if_req_valid  = 1'b0;
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_bus_valid", 64'(bus_req_valid), 64'h0);
    chk("rw_bus_addr", bus_addr, 64'h0);
    chk("rw_if_rsp", 64'(if_rsp_valid), 64'h0);
    step();
    reset         = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'hCAFE_BABE_1234_5678;
    step();
    bus_rsp_valid = 1'b0;
    chk("rw_late_if_rsp", 64'(if_rsp_valid), 64'h0);
    chk("rw_late_if_data", 64'(if_rsp_data), 64'h0);
    step();
    chk("rw_late_if_rsp2", 64'(if_rsp_valid), 64'h0);
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_004C;
    #1;
    chk("rw_next_ready", 64'(if_req_ready), 64'h1);
    step();
    if_req_valid = 1'b0;
    chk("rw_next_addr", bus_addr, 64'h8000_0048);
    bus_serve(64'h1111_1111_2222_2222);
    chk("rw_next_rsp", 64'(if_rsp_valid), 64'h1);
    chk("rw_next_data", 64'(if_rsp_data), 64'h1111_1111);
    step();
    chk("end_arb_err", 64'(arb_err), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_22040931_mem_arbiter.md
Name: ysyx_22040931_mem_arbiter

Overview:
- Shares the core's single memory port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between the pipeline stages and the DPI memory wrapper.
- Serialises accesses through a state machine, with one transaction outstanding at a time.
- Generates byte write masks and lane-aligned store data.
- Routes each response back to the requester that issued it.

Parameters:
- ADDR_W, 64, address width (same as the PC and memory bus).
- STARVE_LIMIT, 4, maximum consecutive MEM grants while IF is waiting; must be >= 1.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  IF fetch request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_req_addr  in  ADDR_W  fetch address, 4-byte aligned.
- if_rsp_valid  out  1  one-cycle pulse: fetched instruction is valid.
- if_rsp_data  out  32  fetched instruction.
- mem_req_valid  in  1  MEM load/store request.
- mem_req_ready  out  1  MEM request accepted this cycle.
- mem_req_addr  in  ADDR_W  byte address.
- mem_req_wr  in  1  1 = store, 0 = load.
- mem_req_size  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D.
- mem_req_wdata  in  64  store data, right-justified.
- mem_rsp_valid  out  1  one-cycle pulse: load data valid, or store completed.
- mem_rsp_rdata  out  64  raw 64-bit memory word; the MEM stage extracts and sign-extends.
- bus_req_valid  out  1  request to the memory port.
- bus_req_ready  in  1  memory port accepts the request.
- bus_addr  out  ADDR_W  address, 8-byte aligned (addr[2:0] forced to 0).
- bus_wr  out  1  write enable.
- bus_wdata  out  64  lane-aligned store data.
- bus_wmask  out  8  byte-lane write mask.
- bus_rsp_valid  in  1  memory response valid.
- bus_rsp_rdata  in  64  memory read data.
- arb_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, starvation counter 0. Reset mid-transaction abandons the transaction; a bus_rsp_valid arriving after reset is ignored.
- FSM states: IDLE, ISSUE_IF, ISSUE_MEM, WAIT_IF, WAIT_MEM.
- IDLE, arbitration:
  - Only MEM valid: MEM wins.
  - Only IF valid: IF wins.
  - Both valid: MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - The winner's req_ready is driven combinationally high in IDLE only; the loser's is 0.
  - On handshake: request fields are latched; next state is ISSUE_IF or ISSUE_MEM.
- Starvation counter:
  - Increments on a MEM grant while if_req_valid = 1.
  - Clears on any IF grant.
  - Saturates at STARVE_LIMIT.
- ISSUE_x:
  - bus_req_valid = 1, driven from the latched fields.
  - Hold all fields stable until bus_req_ready; then go to WAIT_x.
  - bus_rsp_valid seen in ISSUE_x is ignored.
- WAIT_x:
  - bus_req_valid = 0.
  - On bus_rsp_valid: register the response; next cycle pulse the owner's rsp_valid for exactly 1 cycle; return to IDLE in that same cycle.
  - The other requester's rsp_valid stays 0.
- Latency: handshake at cycle T, bus_req_valid at T+1; with bus_req_ready at T+1 and bus_rsp_valid at T+2, rsp_valid rises at T+3. The next grant is possible at T+3.
- IF response: if_rsp_data = latched addr[2] ? rdata[63:32] : rdata[31:0].
- IF requests always use bus_wr = 0 and bus_wmask = 0.
- MEM write mask, with a = addr[2:0]:
  - D: 8'hFF.
  - W: a[2] ? 8'hF0 : 8'h0F.
  - H: 8'h03 << {a[2:1], 1'b0}.
  - B: 8'h01 << a.
  - Loads: mask 0.
- Store data: bus_wdata = mem_req_wdata << (a*8), truncated to 64 bits.
- Misaligned H/W accesses are not checked; the shifted mask is truncated to 8 bits.
- The arbiter never applies backpressure on responses; rsp outputs hold 0 when not pulsing.
- A requester must hold valid and its fields until ready; the arbiter does not require valid to stay high after a non-granted cycle.

Optional Feature:
- Macro: YSYX_22040931_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE_x and WAIT_x.
  - On reaching TIMEOUT_CYC: set arb_err (sticky until reset), deassert bus_req_valid, pulse the owner's rsp_valid with data 0, return to IDLE.
  - A late bus_rsp_valid arriving in IDLE is ignored.
- Not defined: no counter, arb_err tied 0, the FSM waits indefinitely.

Test Plan:
- Reset 3 cycles, then IF addr 0x80000004; bus ready at once, rsp 0xDEADBEEF_00000013 one cycle later -> bus_addr 0x80000000, bus_wmask 0, if_rsp_data 0xDEADBEEF, if_rsp_valid 1 cycle at T+3.
- MEM store size H, addr 0x80000106, wdata 0x1234 -> bus_wmask 0xC0, bus_wdata 0x1234_0000_0000_0000, mem_rsp_valid 1 pulse, if_rsp_valid stays 0.
- IF and MEM both valid continuously, STARVE_LIMIT 4 -> grant order MEM, MEM, MEM, MEM, IF, MEM, ...
- Hold bus_req_ready 0 for 5 cycles in ISSUE_MEM -> bus_addr, bus_wdata and bus_wmask stable; if_req_ready 0 throughout.
- Assert reset in WAIT_IF, then bus_rsp_valid -> all outputs 0, no if_rsp_valid pulse, the next IF request is granted normally.
- With YSYX_22040931_ARB_TIMEOUT_EN and TIMEOUT_CYC 8: never respond -> arb_err set, mem_rsp_valid pulse with data 0, FSM back in IDLE.
